tx_queue_scheduler: RTL
=======================

# tx_queue_scheduler

Packet-atomic round-robin scheduler that shares one tx_queue write port among NUM_QUEUES packet sources in the core clock domain, e.g. per-class output queues feeding one MAC. It grants one source at a time, forwards that source's words through a registered stage to the tx_queue `in_*` interface, and rearbitrates only on end-of-packet. It runs entirely in `clk`; the tx_queue handles the MAC clock crossing.

## Interface
- DATA_WIDTH, 64, data word width; must be 32 or 64, matching tx_queue.
- CTRL_WIDTH, DATA_WIDTH/8, control bits per word.
- NUM_QUEUES, 4, number of sources, 2..8.
- GRANT_WIDTH (localparam), log2(NUM_QUEUES), minimum 1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- src_data  in  NUM_QUEUES*DATA_WIDTH  source i data occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ctrl  in  NUM_QUEUES*CTRL_WIDTH  source i ctrl occupies bits [i*CTRL_WIDTH +: CTRL_WIDTH].
- src_wr  in  NUM_QUEUES  per-source word strobe.
- src_pkt_avail  in  NUM_QUEUES  level; source holds at least one complete packet.
- src_rdy  out  NUM_QUEUES  per-source ready (combinational).
- out_data  out  DATA_WIDTH  to tx_queue in_data (registered).
- out_ctrl  out  CTRL_WIDTH  to tx_queue in_ctrl (registered).
- out_wr  out  1  to tx_queue in_wr (registered).
- out_rdy  in  1  from tx_queue in_rdy, i.e. not almost_full.
- sched_en  in  1  register enable; when low, no new grants are issued.
- grant  out  GRANT_WIDTH  currently or last granted source.
- busy  out  1  high in SEND.
- pkt_done  out  1  one-cycle pulse per forwarded EOP word.
- wr_err  out  1  one-cycle pulse when src_wr is asserted by a source that is not granted, or while IDLE.

## Operation
- A packet is a sequence of words. The first word with src_ctrl != 0 is the EOP and terminates the packet. A single-word packet is legal.
- States: IDLE and SEND, one-hot.
- IDLE:
  - Condition: sched_en and |src_pkt_avail.
  - Action: grant <= first i with src_pkt_avail[i], scanning rr_ptr, rr_ptr+1, … mod NUM_QUEUES; next state SEND.
  - Otherwise remain in IDLE.
- SEND:
  - src_rdy[grant] = out_rdy. All other src_rdy bits are 0. All src_rdy bits are 0 in IDLE.
  - On src_wr[grant], the word is captured into the output register.
  - If that word's ctrl != 0: pkt_done=1, rr_ptr <= (grant+1) mod NUM_QUEUES, next state IDLE.
- sched_en deasserting during SEND does not abort the packet; it only blocks the next grant.
- src_wr from a non-granted source, or any src_wr in IDLE: the word is dropped, wr_err pulses, and state is unchanged.
- src_wr[grant] while src_rdy is low (protocol violation): the word is still forwarded. tx_queue almost_full slack absorbs it.
- rr_ptr wraps from NUM_QUEUES-1 to 0. If only one source is available, it is re-granted every time.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant 0.
  - out_wr 0, out_data 0, out_ctrl 0.
  - busy 0, pkt_done 0, wr_err 0, src_rdy all 0.
- Arbitration: src_pkt_avail sampled high in IDLE gives busy and src_rdy the next cycle.
- Datapath latency: src_wr at cycle N gives out_wr, out_data and out_ctrl at N+1. pkt_done is registered, aligned with the out_wr of the EOP word.
- Packet gap: EOP accepted at N, IDLE at N+1, new grant visible at N+2. Minimum one dead cycle between packets.
- out_rdy is used combinationally in src_rdy, so out_rdy low at cycle N stops new src words at N. At most one word already in the output register is still written; almost_full slack covers it.
- Reset mid-packet:
  - Everything returns to reset values the next cycle, and the partial packet is truncated.
  - The verifier checks only that no out_wr occurs in the cycle after reset.

## Test plan
- Single source: NUM_QUEUES=4, only src 2 avail, 3-word packet with ctrl 00,00,80 -> out_wr at 3 consecutive cycles with identical data/ctrl, one pkt_done, grant=2, rr_ptr=3.
- Round robin: all 4 sources always avail, 2-word packets, rr_ptr=0 -> grant order 0,1,2,3,0; exactly one idle cycle between packets.
- Backpressure: out_rdy low for 5 cycles mid-packet -> src_rdy low for exactly those cycles, no word lost or duplicated, ≤1 out_wr after out_rdy falls.
- Atomicity: src 1 becomes avail during a 10-word src 0 packet -> no src 1 word appears until src 0's EOP; then grant=1.
- Enable and errors:
  - sched_en=0 with all avail -> busy stays 0.
  - sched_en dropped mid-packet -> packet completes, then no new grant.
  - src_wr[3] while grant=0 -> wr_err pulse, nothing forwarded.
- Reset mid-packet: reset on word 2 of 4 -> next cycle out_wr=0, busy=0, grant=0; next packet from rr_ptr 0 forwards correctly.

Source files
------------

// File: rtl/tx_queue_scheduler.sv
// Packet-atomic round-robin scheduler sharing one tx_queue write port among NUM_QUEUES sources.
// The granted source's words pass through one register stage; rearbitration happens only after EOP.
module tx_queue_scheduler #(
    parameter int  DATA_WIDTH  = 64,
    parameter int  CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int  NUM_QUEUES  = 4,
    localparam int GRANT_WIDTH = (NUM_QUEUES > 2) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] src_ctrl,
    input  logic [NUM_QUEUES-1:0]            src_wr,
    input  logic [NUM_QUEUES-1:0]            src_pkt_avail,
    output logic [NUM_QUEUES-1:0]            src_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic                             sched_en,
    output logic [GRANT_WIDTH-1:0]           grant,
    output logic                             busy,
    output logic                             pkt_done,
    output logic                             wr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_SEND = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [GRANT_WIDTH-1:0]  grant_q, grant_d;
    logic [GRANT_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
    logic                    out_wr_q, out_wr_d;
    logic                    pkt_done_q, pkt_done_d;
    logic                    wr_err_q, wr_err_d;

    logic                    in_send;
    logic [NUM_QUEUES-1:0]   grant_mask;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [CTRL_WIDTH-1:0]   sel_ctrl;
    logic [GRANT_WIDTH-1:0]  rr_next;
    logic [GRANT_WIDTH-1:0]  pick;
    logic                    pick_valid;

    assign in_send = (state_q == S_SEND);

    always_comb begin
        grant_mask = '0;
        if (in_send) begin
            grant_mask[grant_q] = 1'b1;
        end
    end

    // out_rdy is deliberately combinational here so a full tx_queue stops the source the same cycle.
    assign src_rdy  = grant_mask & {NUM_QUEUES{out_rdy}};
    assign sel_data = src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_ctrl = src_ctrl[int'(grant_q)*CTRL_WIDTH +: CTRL_WIDTH];
    assign rr_next  = (grant_q == GRANT_WIDTH'(NUM_QUEUES - 1)) ? '0 : grant_q + 1'b1;

    // Scan downwards so the candidate closest to rr_ptr is the last one written and wins.
    always_comb begin
        pick       = rr_ptr_q;
        pick_valid = 1'b0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            if (src_pkt_avail[(int'(rr_ptr_q) + k) % NUM_QUEUES]) begin
                pick       = GRANT_WIDTH'((int'(rr_ptr_q) + k) % NUM_QUEUES);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        out_wr_d   = 1'b0;
        pkt_done_d = 1'b0;
        wr_err_d   = |(src_wr & ~grant_mask);

        unique case (state_q)
            S_IDLE: begin
                if (sched_en && pick_valid) begin
                    grant_d = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // The granted word is taken even if out_rdy is low; tx_queue slack absorbs it.
                if (src_wr[grant_q]) begin
                    out_wr_d   = 1'b1;
                    out_data_d = sel_data;
                    out_ctrl_d = sel_ctrl;
                    if (|sel_ctrl) begin
                        pkt_done_d = 1'b1;
                        rr_ptr_d   = rr_next;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            out_wr_q   <= 1'b0;
            pkt_done_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            out_wr_q   <= out_wr_d;
            pkt_done_q <= pkt_done_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign out_wr   = out_wr_q;
    assign grant    = grant_q;
    assign busy     = in_send;
    assign pkt_done = pkt_done_q;
    assign wr_err   = wr_err_q;

endmodule
